// File: rtl/shift_reg_pkg.sv
// Shared types and helpers for the shift-register family (PISO tx / SIPO rx).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package shift_reg_pkg;

   // Serializer control states: idle, or a word is on the wire.
   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } tx_state_t;

   localparam int DEFAULT_WIDTH = 4;

   // The bit index needs at least one bit, even for single-bit words.
   function automatic int cnt_width(input int w);
      if ($clog2(w) < 1) begin
         return 1;
      end
      return $clog2(w);
   endfunction

endpackage

// File: rtl/bit_index_counter.sv
// Modulo-WIDTH bit index with clear, enable and terminal-count flag.
// Latency: count updates on the edge after en/clr; tc is decoded from the register.
// Backpressure: none; the owner decides when to advance.
module bit_index_counter
   import shift_reg_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int CW    = cnt_width(WIDTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          en,
   output logic [CW-1:0] cnt,
   output logic          tc
);

   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Next index: clear wins over enable; wraps to zero after the last bit.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = tc ? '0 : cnt_q + CW'(1);
      end
   end

   // Index register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;
   assign tc  = (cnt_q == LAST);

endmodule

// File: rtl/parallel_in_serial_out_tx.sv
// Serializes a WIDTH-bit word one bit per clock with per-bit valid and sof/eof marks.
// Latency: word accepted at edge N drives its first bit in cycle N+1, last in N+WIDTH.
// Backpressure: d_ready only when idle or on the last bit, giving gapless back-to-back words.
module parallel_in_serial_out_tx
   import shift_reg_pkg::*;
#(
   parameter int WIDTH     = DEFAULT_WIDTH,
   parameter bit LSB_FIRST = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   input  logic             d_valid,
   output logic             d_ready,
   output logic             sout,
   output logic             sout_valid,
   output logic             sof,
   output logic             eof,
   output logic             busy
);

   localparam int CW = cnt_width(WIDTH);

   tx_state_t        state_q;
   tx_state_t        state_d;
   logic [WIDTH-1:0] sreg_q;
   logic [WIDTH-1:0] sreg_d;
   logic             cnt_clr;
   logic             cnt_en;
   logic [CW-1:0]    cnt;
   logic             last_bit;
   logic             shifting;
   logic             accept;

   bit_index_counter #(
      .WIDTH (WIDTH),
      .CW    (CW)
   ) u_bit_index_counter (
      .clk (clk),
      .rst (rst),
      .clr (cnt_clr),
      .en  (cnt_en),
      .cnt (cnt),
      .tc  (last_bit)
   );

   // All outputs come straight from registered state; no input-to-output path.
   assign shifting   = (state_q == SHIFT);
   assign busy       = shifting;
   assign sout_valid = shifting;
   assign d_ready    = !shifting || last_bit;
   assign sof        = shifting && (cnt == '0);
   assign eof        = shifting && last_bit;
   assign sout       = shifting && (LSB_FIRST ? sreg_q[0] : sreg_q[WIDTH-1]);

   assign accept = d_valid && d_ready;

   // Next state, shift-register load/shift and counter control.
   always_comb begin
      state_d = state_q;
      sreg_d  = sreg_q;
      cnt_clr = 1'b0;
      cnt_en  = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               sreg_d  = d;
               cnt_clr = 1'b1;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (last_bit) begin
               // Last bit on the wire: reload for a gapless follow-on word or go idle.
               cnt_clr = 1'b1;
               if (accept) begin
                  sreg_d = d;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               sreg_d = LSB_FIRST ? (sreg_q >> 1) : (sreg_q << 1);
               cnt_en = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and shift register with synchronous reset; reset beats a same-edge accept.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         sreg_q  <= '0;
      end else begin
         state_q <= state_d;
         sreg_q  <= sreg_d;
      end
   end

endmodule

// File: tb/tb_parallel_in_serial_out_tx.sv
// Bench for parallel_in_serial_out_tx: MSB-first, LSB-first and single-bit variants.
// Latency: checks every cycle against a word/position reference model.
// Backpressure: model decides acceptance from its own notion of readiness.
module tb_parallel_in_serial_out_tx;

   logic       clk = 1'b0;
   logic       rst;
   logic       d_valid;
   logic [3:0] d_in;

   logic [2:0] rdy, bsy, sv, sf, ef, so;

   int vec_cnt = 0;
   int err_cnt = 0;

   // Reference model: per instance, the word in flight and which bit of it is on the wire.
   int         m_w    [3] = '{4, 4, 1};
   bit         m_lsb  [3] = '{1'b0, 1'b1, 1'b0};
   bit         m_act  [3];
   int         m_pos  [3];
   logic [3:0] m_word [3];

   // Serial bits captured while sout_valid, per instance.
   logic [31:0] hist [3];
   int          cyc = 0;

   always #5 clk = ~clk;

   parallel_in_serial_out_tx #(.WIDTH(4), .LSB_FIRST(1'b0)) u_msb (
      .clk(clk), .rst(rst), .d(d_in), .d_valid(d_valid), .d_ready(rdy[0]),
      .sout(so[0]), .sout_valid(sv[0]), .sof(sf[0]), .eof(ef[0]), .busy(bsy[0])
   );

   parallel_in_serial_out_tx #(.WIDTH(4), .LSB_FIRST(1'b1)) u_lsb (
      .clk(clk), .rst(rst), .d(d_in), .d_valid(d_valid), .d_ready(rdy[1]),
      .sout(so[1]), .sout_valid(sv[1]), .sof(sf[1]), .eof(ef[1]), .busy(bsy[1])
   );

   parallel_in_serial_out_tx #(.WIDTH(1), .LSB_FIRST(1'b0)) u_w1 (
      .clk(clk), .rst(rst), .d(d_in[0:0]), .d_valid(d_valid), .d_ready(rdy[2]),
      .sout(so[2]), .sout_valid(sv[2]), .sof(sf[2]), .eof(ef[2]), .busy(bsy[2])
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Expected {d_ready, busy, sout_valid, sof, eof, sout} from the model.
   function automatic logic [5:0] model_vec(input int i);
      int  idx;
      bit  last;
      if (!m_act[i]) begin
         return 6'b100000;
      end
      last = (m_pos[i] == m_w[i] - 1);
      idx  = m_lsb[i] ? m_pos[i] : (m_w[i] - 1 - m_pos[i]);
      return {last, 1'b1, 1'b1, (m_pos[i] == 0), last, m_word[i][idx]};
   endfunction

   // One clock: check outputs mid-cycle, apply inputs, advance the model for the coming edge.
   task automatic step(input logic r, input logic v, input logic [3:0] dat);
      logic [5:0] obs;
      bit         ready;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         obs = {rdy[i], bsy[i], sv[i], sf[i], ef[i], so[i]};
         chk($sformatf("dut%0d_cyc%0d", i, cyc), {26'd0, obs}, {26'd0, model_vec(i)});
         if (sv[i] === 1'b1) begin
            hist[i] = {hist[i][30:0], so[i]};
         end
      end
      rst     = r;
      d_valid = v;
      d_in    = dat;
      for (int i = 0; i < 3; i++) begin
         ready = !m_act[i] || (m_pos[i] == m_w[i] - 1);
         if (r) begin
            m_act[i] = 1'b0;
            m_pos[i] = 0;
         end else if (v && ready) begin
            m_act[i]  = 1'b1;
            m_pos[i]  = 0;
            m_word[i] = dat;
         end else if (m_act[i]) begin
            if (m_pos[i] == m_w[i] - 1) begin
               m_act[i] = 1'b0;
            end else begin
               m_pos[i]++;
            end
         end
      end
      cyc++;
      @(posedge clk);
   endtask

   task automatic clear_hist();
      for (int i = 0; i < 3; i++) begin
         hist[i] = '0;
      end
   endtask

   initial begin
      rst     = 1'b1;
      d_valid = 1'b1;
      d_in    = 4'b1011;
      for (int i = 0; i < 3; i++) begin
         m_act[i]  = 1'b0;
         m_pos[i]  = 0;
         m_word[i] = '0;
      end
      clear_hist();
      @(posedge clk);

      // Reset held with d_valid asserted: nothing may be accepted.
      repeat (3) step(1'b1, 1'b1, 4'b1011);

      // Single word pulsed for one cycle.
      clear_hist();
      step(1'b0, 1'b1, 4'b1011);
      repeat (5) step(1'b0, 1'b0, 4'b0000);
      chk("single_msb", hist[0], 32'b1011);
      chk("single_lsb", hist[1], 32'b1101);
      chk("single_w1", hist[2], 32'b1);

      // Back-to-back words with valid held high.
      clear_hist();
      step(1'b0, 1'b1, 4'b1011);
      repeat (3) step(1'b0, 1'b1, 4'b1011);
      repeat (4) step(1'b0, 1'b1, 4'b0110);
      repeat (5) step(1'b0, 1'b0, 4'b0000);
      chk("b2b_msb", hist[0], 32'b10110110);
      chk("b2b_lsb", hist[1], 32'b11010110);

      // New data presented while the word is in flight is held off.
      clear_hist();
      step(1'b0, 1'b1, 4'b1011);
      repeat (4) step(1'b0, 1'b1, 4'b0000);
      repeat (5) step(1'b0, 1'b0, 4'b1111);
      chk("holdoff_msb", hist[0], 32'b10110000);

      // Reset during bit 2 drops the rest of the word.
      step(1'b0, 1'b1, 4'b1011);
      step(1'b0, 1'b0, 4'b0000);
      step(1'b1, 1'b0, 4'b0000);
      clear_hist();
      step(1'b0, 1'b1, 4'b0101);
      repeat (5) step(1'b0, 1'b0, 4'b0000);
      chk("abort_msb", hist[0], 32'b0101);
      chk("abort_lsb", hist[1], 32'b1010);

      // Random traffic with occasional resets.
      for (int n = 0; n < 2000; n++) begin
         step(($urandom_range(63) == 0), ($urandom_range(9) < 7), 4'($urandom));
      end
      repeat (5) step(1'b0, 1'b0, 4'b0000);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/parallel_in_serial_out_tx.md
Name: parallel_in_serial_out_tx

Overview:
Transmit-side serializer for the team's shift-register family. It accepts a WIDTH-bit parallel word on a valid/ready handshake and shifts it out one bit per clock, with per-bit valid and start/end-of-word markers. A word may be accepted on the last bit of the previous word, so a continuously fed stream has no idle gap. It pairs with the serial-in/parallel-out receiver on the far end of the link.

Parameters:
WIDTH, 4, word width in bits; legal range is 1 or more.
LSB_FIRST, 0, 0 sends MSB first; 1 sends LSB first.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
d  input  WIDTH  parallel word to transmit
d_valid  input  1  upstream has a word on d
d_ready  output  1  block can accept a word this cycle
sout  output  1  serial data bit
sout_valid  output  1  sout carries a valid bit
sof  output  1  current bit is the first bit of a word
eof  output  1  current bit is the last bit of a word
busy  output  1  a word is being shifted out

Behaviour:
- Reset is synchronous (rst sampled on the clk rising edge) and active-high.
- Reset state: state IDLE, shift register 0, bit counter 0.
- Output values in reset: sout=0, sout_valid=0, sof=0, eof=0, busy=0, d_ready=1.
- State register has two states: IDLE and SHIFT. Bit counter is clog2(WIDTH) bits wide, minimum 1 bit.
- All outputs are decoded from registers only; there is no combinational path from input to output.
  - busy = sout_valid = (state==SHIFT)
  - d_ready = (state==IDLE) or (state==SHIFT and cnt==WIDTH-1)
  - sof = sout_valid and cnt==0
  - eof = sout_valid and cnt==WIDTH-1
  - sout = shift-register MSB (LSB_FIRST=0) or LSB (LSB_FIRST=1), gated to 0 when not valid
- Accept: d_valid and d_ready at a clock edge. On accept the shift register loads d, cnt becomes 0 and state becomes SHIFT.
- Latency: a word accepted at edge N drives its first bit in cycle N+1. The word then occupies cycles N+1 through N+WIDTH.
- SHIFT with cnt < WIDTH-1: each edge shifts the register by one (left for MSB-first, right for LSB-first), zero-fills, and increments cnt. d and d_valid are ignored.
- SHIFT with cnt == WIDTH-1 (last bit):
  - If a word is accepted, reload and set cnt=0, staying in SHIFT. This gives gapless back-to-back transmission.
  - Otherwise go to IDLE.
- d_valid while d_ready=0 has no effect. Upstream must hold d and d_valid until accepted. Changes to d during a word never corrupt the word in flight.
- rst mid-word: the word is aborted and its partial bits discarded. All outputs return to reset values after that edge. rst overrides a simultaneous accept.
- WIDTH=1: every bit has sof=eof=1 and d_ready stays 1 in SHIFT. A continuously valid source gives one word per cycle.
- No underflow or overflow states exist. Upstream holding d_valid=0 simply leaves the block in IDLE.

Decomposition:
- Shared package (shift_reg_pkg):
  - state enum typedef tx_state_t {IDLE, SHIFT}
  - constant DEFAULT_WIDTH = 4
  - function cnt_width(w) returning max(1, clog2(w))
  - The paired receiver reuses the same package.
- One natural sub-module: bit_index_counter. It is a modulo-WIDTH counter with clear and enable inputs and a terminal-count output, and the receiver reuses it. The shift register and FSM stay in the top module.

Test Plan:
1. Reset: hold rst for 3 cycles with d_valid=1 -> sout_valid=0, busy=0, sof=eof=0, sout=0, d_ready=1 throughout; no word is accepted.
2. Single word, WIDTH=4, LSB_FIRST=0, d=4'b1011 pulsed for one cycle -> sout=1,0,1,1 in the four cycles after accept; sof only on bit 1, eof only on bit 4; d_ready=0 on bits 1–3 and 1 on bit 4; IDLE on the following cycle.
3. Back-to-back: d=4'b1011 then 4'b0110 with d_valid held high -> 8 contiguous valid bits 1,0,1,1,0,1,1,0 with no gap; sof on bits 1 and 5, eof on bits 4 and 8.
4. LSB_FIRST=1, d=4'b1011 -> sout=1,1,0,1; sof and eof timing as in scenario 2.
5. Hold-off: after accepting 4'b1011, drive d=4'b0000 with d_valid=1 during bits 1–3 -> transmitted bits are still 1,0,1,1; 4'b0000 is accepted on the bit-4 edge and sent next.
6. Mid-word reset: assert rst for one cycle during bit 2 of 4'b1011 -> sout_valid=0 the next cycle and the remaining bits are dropped. A following word 4'b0101 then transmits cleanly as 0,1,0,1 with sof on its first bit.
